mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and select controller for the shared 4-lane, 4:1 select mux (`mux16for4`). Four requesters compete for the mux; the block grants one at a time and drives the mux select pair `s0`/`s1` so the granted source (a/b/c/d) reaches `y0..y3`. Outputs are registered, so the mux select never glitches mid-grant. Sits between the source controllers and the mux instance.

## Interface
- `MAX_HOLD`, 8, maximum cycles one grant may be held while others wait (legal 2..255; used only with `MUX_ARB_TIMEOUT_EN`)
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  4  per-requester request; bit0 = source a, bit1 = b, bit2 = c, bit3 = d; level-held for the whole transfer
- `gnt`  out  4  one-hot grant, registered
- `valid`  out  1  high while any grant is active (mux output meaningful)
- `s0`  out  1  mux select, MSB (c, d)
- `s1`  out  1  mux select, LSB (b, d)
- `owner`  out  2  index of the current or most recent owner

## Operation
- **States:**
  - `IDLE`: no grant, `valid`=0.
  - `GRANT`: one owner.
  - `RELEASE`: one dead cycle, `valid`=0, `gnt`=0, `s0`/`s1` hold their last value.
- **IDLE:** if any `req` is set, pick a winner, load `owner`/`gnt`/`s0`/`s1`, and go to `GRANT`. Otherwise stay in `IDLE`.
- **RELEASE:** arbitrates exactly like `IDLE`, with the same next-state rule.
- **GRANT:**
  - Stays while `req[owner]`=1.
  - When `req[owner]`=0, goes to `RELEASE`.
- **Winner selection:** rotating priority starting at `(owner+1) mod 4` and wrapping 3→0. The index that owned most recently has the lowest priority.
- **Select encoding:** `{s0,s1}` = `owner`.
  - a = 00, b = 01, c = 10, d = 11.
- **Simultaneous events:**
  - The owner dropping its request while others are requesting still inserts `RELEASE`. There is no back-to-back grant.
  - `req` bits of non-owners toggling during `GRANT` have no effect.
- **Reset mid-grant:** the grant is revoked at that edge with no `RELEASE` cycle. The pointer restarts with a priority order of 0,1,2,3.

## Timing
- **Reset values:** `gnt`=0000, `valid`=0, `s0`=0, `s1`=0, `owner`=3 (so requester 0 wins first), state `IDLE`, hold counter 0.
- **Grant latency:** `req` sampled high at edge N gives `gnt`/`valid`/select valid after edge N (1 cycle).
- **Release latency:**
  - Owner `req` sampled low at edge N: `gnt`=0 after edge N.
  - Next grant appears after edge N+1, so the handover gap is exactly 1 cycle.
- **Select stability:** `s0`/`s1` change only on the edge that enters `GRANT`.

## Configuration
- **`MUX_ARB_TIMEOUT_EN` defined:**
  - A hold counter (8 bits, saturating) counts cycles spent in `GRANT`. It clears on entry to `GRANT`.
  - When the count reaches `MAX_HOLD`-1 and any non-owner `req` is set, the state is forced to `RELEASE` at the next edge, even with `req[owner]`=1.
  - The pre-empted owner has the lowest priority afterwards and may re-win later.
  - With no competing request, the grant continues and the counter saturates.
- **Undefined:** no counter; a grant lasts until the owner drops `req`, and `MAX_HOLD` is ignored.

## Structure
- **Package `mux_arb_pkg`:**
  - state enum (`IDLE`, `GRANT`, `RELEASE`);
  - select constants `SEL_A`..`SEL_D` (2'b00..2'b11);
  - `NREQ`=4.
- **Sub-module `rr_pick`:** combinational rotate-priority encoder (`req[3:0]`, `last[1:0]` → `win[1:0]`, `any`). Instantiated once.
- **Top level:** FSM, registers, and the optional counter.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `req`=1111 → all outputs at their reset values. After release, `req`=1111 gives `gnt`=0001, `s0s1`=00 one cycle later.
- **Rotation:** `req`=1111, with each owner dropping its `req` after 3 cycles and re-raising it → grant order 0,1,2,3,0. Check the 1-cycle `valid`=0 gap each time and `s0s1` of 00,01,10,11.
- **Single requester:** `req`=0100 for 10 cycles → `gnt`=0100, `s0s1`=10, steady with no glitch. Then `req`=0 → `IDLE` after `RELEASE`.
- **Skip idle requesters:** owner=1 releases with `req`=0001 → `gnt`=0001, since rotation wraps past 2 and 3.
- **Timeout (`MUX_ARB_TIMEOUT_EN`, `MAX_HOLD`=4):** `req`=0011 held continuously → owner 0 for 4 cycles, 1 dead cycle, then owner 1 for 4 cycles, alternating. Repeat with `req`=0001 only → the grant persists indefinitely.
- **Reset mid-grant:** owner=2 in `GRANT` and `rst_n`=0 for one cycle → `gnt`=0 immediately. With `req`=0110 held, the next grant goes to 1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin mux select arbiter.
package mux_arb_pkg;
    localparam int NREQ  = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the search starts at last+1 and wraps, so 'last' ranks lowest.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      win,
    output logic            any
);
    logic [1:0] idx;

    // Walk from lowest to highest priority so the highest-priority request wins last.
    always_comb begin
        win = last;
        idx = last;
        any = |req;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) win = idx;
        end
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select pair; all outputs registered.
// Optional grant hold timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       s0,
    output logic       s1,
    output logic [1:0] owner
);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] gnt_nxt;
    logic       valid_nxt;
    logic [1:0] owner_nxt;
    logic [1:0] sel, sel_nxt;
    logic [1:0] win;
    logic       any;
    logic       preempt;

    rr_pick u_pick (
        .req  (req),
        .last (owner),
        .win  (win),
        .any  (any)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    // Saturating: a long solo grant can still be pre-empted once a competitor shows up.
    always_ff @(posedge clk) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (state != GRANT)
            hold_cnt <= '0;
        else if (hold_cnt != '1)
            hold_cnt <= hold_cnt + 1'b1;
    end

    assign preempt = (state == GRANT) && (hold_cnt >= HOLD_LIM) && (|(req & ~gnt));
`else
    logic unused_hold;
    assign unused_hold = ^HOLD_LIM;
    assign preempt     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        valid_nxt = valid;
        owner_nxt = owner;
        sel_nxt   = sel;
        case (state)
            IDLE, RELEASE: begin
                if (any) begin
                    state_nxt = GRANT;
                    owner_nxt = win;
                    gnt_nxt   = 4'b0001 << win;
                    valid_nxt = 1'b1;
                    sel_nxt   = win;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (!req[owner] || preempt) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // owner resets to 3 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
            owner <= 2'd3;
            sel   <= SEL_A;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            valid <= valid_nxt;
            owner <= owner_nxt;
            sel   <= sel_nxt;
        end
    end

    assign s0 = sel[1];
    assign s1 = sel[0];
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter; expectations are queued as each cycle is driven.
module tb_mux4_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic       s0;
    logic       s1;
    logic [1:0] owner;

    typedef struct {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] sel;
        logic [1:0] own;
    } exp_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    logic [1:0] last;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .valid (valid),
        .s0    (s0),
        .s1    (s1),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] o);
        return 4'b0001 << o;
    endfunction

    // One clock: drive inputs, queue the outputs expected after the edge, then compare.
    task automatic cyc(input logic r, input logic [3:0] q, input logic [3:0] eg,
                       input logic ev, input logic [1:0] es, input logic [1:0] eo);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = q;
        e.gnt = eg; e.valid = ev; e.sel = es; e.own = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt",   8'(gnt),       8'(e.gnt));
        chk("valid", 8'(valid),     8'(e.valid));
        chk("sel",   8'({s0, s1}),  8'(e.sel));
        chk("owner", 8'(owner),     8'(e.own));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'h0;
        last   = 2'd0;

        // reset with all requesting, then first grant goes to 0
        repeat (2) cyc(1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 2'd3);
        cyc(1'b1, 4'hF, 4'b0001, 1'b1, 2'd0, 2'd0);

        // rotation 0,1,2,3,0 with one dead cycle per handover
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kk, nk;
            kk = 2'(k);
            nk = kk + 2'd1;
            repeat (2) cyc(1'b1, 4'hF, oh(kk), 1'b1, kk, kk);
            cyc(1'b1, 4'hF & ~oh(kk), 4'h0, 1'b0, kk, kk);
            cyc(1'b1, 4'hF, oh(nk), 1'b1, nk, nk);
        end
        repeat (2) cyc(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0);

        // single requester c
        repeat (10) cyc(1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2);
        repeat (2) cyc(1'b1, 4'h0, 4'h0, 1'b0, 2'd2, 2'd2);

        // owner 1 ignores non-owner toggles, then wrap past 2,3 to 0
        cyc(1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd1);
        cyc(1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1, 2'd1);
        cyc(1'b1, 4'b1011, 4'b0010, 1'b1, 2'd1, 2'd1);
        cyc(1'b1, 4'b0001, 4'h0,    1'b0, 2'd1, 2'd1);
        cyc(1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 2'd0);
        repeat (2) cyc(1'b1, 4'h0, 4'h0, 1'b0, 2'd0, 2'd0);

        // two continuous requesters
        for (int c = 0; c < 15; c++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            logic [1:0] o;
            o = (((c / 5) % 2) == 0) ? 2'd1 : 2'd0;
            if ((c % 5) == 4)
                cyc(1'b1, 4'b0011, 4'h0, 1'b0, o, o);
            else
                cyc(1'b1, 4'b0011, oh(o), 1'b1, o, o);
`else
            cyc(1'b1, 4'b0011, 4'b0010, 1'b1, 2'd1, 2'd1);
`endif
        end
        repeat (2) cyc(1'b1, 4'h0, 4'h0, 1'b0, 2'd1, 2'd1);

        // lone requester holds indefinitely, then a competitor arrives
        repeat (260) cyc(1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 2'd0);
`ifdef MUX_ARB_TIMEOUT_EN
        cyc(1'b1, 4'b0011, 4'h0,    1'b0, 2'd0, 2'd0);
        cyc(1'b1, 4'b0011, 4'b0010, 1'b1, 2'd1, 2'd1);
        last = 2'd1;
`else
        repeat (2) cyc(1'b1, 4'b0011, 4'b0001, 1'b1, 2'd0, 2'd0);
        last = 2'd0;
`endif
        repeat (2) cyc(1'b1, 4'h0, 4'h0, 1'b0, last, last);

        // reset while owner 2 holds; priority restarts at 0
        cyc(1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 2'd2);
        cyc(1'b0, 4'b0110, 4'h0,    1'b0, 2'd0, 2'd3);
        cyc(1'b1, 4'b0110, 4'b0010, 1'b1, 2'd1, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
